// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and FSM state encoding shared by the ALU pipeline
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - unsigned shift-add multiplier, one partial product per cycle, WIDTH iterations
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_prod_next;

    // Product is exposed one step early so the owner can latch it on the final iteration edge.
    assign w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign o_done       = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
    assign {o_hi, o_lo} = w_prod_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered handshake ALU with accumulator chaining; ALU_PIPE_MUL_EN enables iterative MUL
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             op_err
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_err;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

    assign w_accept = in_valid & in_ready;
    assign w_a      = acc_sel ? r_acc : a;

`ifdef ALU_PIPE_MUL_EN
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_mul_hi;

    assign w_is_mul = (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept & w_is_mul),
        .i_a     (w_a),
        .i_b     (b),
        .o_done  (w_mul_done),
        .o_lo    (w_mul_lo),
        .o_hi    (w_mul_hi)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_mul_done) w_next_state = ST_DONE;
            ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_is_mul ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
        out_valid = (r_state == ST_DONE);
    end

    // Subtraction reuses the adder as a + ~b + 1, so carry is the inverted borrow.
    always_comb begin
        w_b_eff = b;
        w_cin   = 1'b0;
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (op == OP_SUB) begin
                    w_b_eff = ~b;
                    w_cin   = 1'b1;
                end
                w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND: w_res = w_a & b;
            OP_OR:  w_res = w_a | b;
            OP_XOR: w_res = w_a ^ b;
            OP_NOT: w_res = ~w_a;
            OP_SHL: w_res = w_a << b[SH_W-1:0];
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: w_err = 1'b0;
`else
            OP_MUL: w_err = 1'b1;
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (out_valid & out_ready) begin
                r_acc <= r_result;
            end
            if (w_accept & ~w_is_mul) begin
                r_result <= w_res;
                r_carry  <= w_carry;
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[WIDTH-1];
                r_ovf    <= w_ovf;
                r_err    <= w_err;
            end
`ifdef ALU_PIPE_MUL_EN
            else if ((r_state == ST_BUSY) & w_mul_done) begin
                r_result <= w_mul_lo;
                r_carry  <= |w_mul_hi;
                r_zero   <= (w_mul_lo == '0);
                r_neg    <= w_mul_lo[WIDTH-1];
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
`endif
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;
    assign zero      = r_zero;
    assign negative  = r_neg;
    assign overflow  = r_ovf;
    assign op_err    = r_err;

endmodule
